// File: rtl/game_input_pkg.sv
// Shared definitions for the breakout game input front end: debounce FSM
// encoding, channel indices and default timing.
package game_input_pkg;

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_PRESSED      = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } deb_state_t;

   localparam int CH_LEFT  = 0;
   localparam int CH_RIGHT = 1;
   localparam int CH_START = 2;
   localparam int NUM_CH   = 3;

   // 5 ms at 100 MHz
   localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;
   localparam int unsigned DEFAULT_CNT_W           = 20;

endpackage

// File: rtl/button_debounce.sv
// One button channel: 2-flop synchroniser followed by a stable-count
// debounce FSM producing a clean level and a one-clk rise strobe.
module button_debounce
   import game_input_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise
);

   // The cycle that first sees the new level counts as the first stable
   // cycle, so a wait state is left after DEBOUNCE_CYCLES-1 further cycles.
   localparam logic [CNT_W-1:0] LAST_CNT =
      (DEBOUNCE_CYCLES > 1) ? CNT_W'(DEBOUNCE_CYCLES - 2) : '0;
   localparam bit SINGLE = (DEBOUNCE_CYCLES == 1);

   logic             r_sync1;
   logic             r_sync2;
   deb_state_t       r_state;
   deb_state_t       w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_rise;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= raw;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_rise      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_sync2) begin
               if (SINGLE) begin
                  w_state_nxt = ST_PRESSED;
                  w_rise      = 1'b1;
               end else begin
                  w_state_nxt = ST_PRESS_WAIT;
               end
            end
         end
         ST_PRESS_WAIT: begin
            if (!r_sync2) begin
               w_state_nxt = ST_IDLE;
            end else if (r_cnt == LAST_CNT) begin
               w_state_nxt = ST_PRESSED;
               w_rise      = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_PRESSED: begin
            if (!r_sync2) begin
               w_state_nxt = SINGLE ? ST_IDLE : ST_RELEASE_WAIT;
            end
         end
         ST_RELEASE_WAIT: begin
            if (r_sync2) begin
               w_state_nxt = ST_PRESSED;
            end else if (r_cnt == LAST_CNT) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      // Every state entry restarts the count, so it can never wrap.
      if (w_state_nxt != r_state) begin
         w_cnt_nxt = '0;
      end
   end

   assign level = (r_state == ST_PRESSED) || (r_state == ST_RELEASE_WAIT);
   assign rise  = w_rise;

endmodule

// File: rtl/game_input_conditioner.sv
// Board pushbuttons to game controls: debounced, mutually exclusive
// left/right levels and a start pulse one game tick wide.
module game_input_conditioner
   import game_input_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_en,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_start,
   output logic       left,
   output logic       right,
   output logic       start,
   output logic [2:0] db_state
);

   logic [NUM_CH-1:0] w_raw;
   logic [NUM_CH-1:0] w_level;
   logic [NUM_CH-1:0] w_rise;
   logic              w_unused_rise;
   logic              r_left;
   logic              r_right;
   logic              r_start;
   logic              r_pending;

   assign w_raw[CH_LEFT]  = btn_left;
   assign w_raw[CH_RIGHT] = btn_right;
   assign w_raw[CH_START] = btn_start;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      button_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W)
      ) u_db (
         .clk  (clk),
         .rst  (rst),
         .raw  (w_raw[g]),
         .level(w_level[g]),
         .rise (w_rise[g])
      );
   end

   // Only the start channel's press edge is consumed.
   assign w_unused_rise = w_rise[CH_LEFT] & w_rise[CH_RIGHT];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_left    <= 1'b0;
         r_right   <= 1'b0;
         r_start   <= 1'b0;
         r_pending <= 1'b0;
      end else begin
         r_left  <= w_level[CH_LEFT] & ~w_level[CH_RIGHT];
         r_right <= w_level[CH_RIGHT] & ~w_level[CH_LEFT];
         // start follows pending on each tick: a pending press raises it,
         // an empty tick drops it, both together extend it one more tick.
         if (tick_en) begin
            r_start <= r_pending;
         end
         if (w_rise[CH_START]) begin
            r_pending <= 1'b1;
         end else if (tick_en) begin
            r_pending <= 1'b0;
         end
      end
   end

   assign left     = r_left;
   assign right    = r_right;
   assign start    = r_start;
   assign db_state = w_level;

endmodule
